// File: rtl/case8_stim_checker.sv
// -----------------------------------------------------------------------------
// case8_stim_checker
//
// Sequential driver and checker for the combinational case8 logic block.
// On start it walks the inclusive vector range START_VEC..END_VEC, drives each
// 10-bit vector onto vec_out, holds it for SETTLE_CYCLES cycles, then samples
// dut_y for one cycle and compares it against an internal golden model of
// case8. It reports the mismatch count, the first failing vector and pass/fail.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//   START_VEC      first vector driven (0..1023)
//   END_VEC        last vector driven (START_VEC..1023)
//
// Build option:
//   CASE8_STOP_ON_ERR_EN  when defined, the first mismatch ends the sweep
//                         immediately (err_count = 1); otherwise the whole
//                         range is always walked and every mismatch counted.
//
// Ports:
//   clk              in   1   clock, rising edge
//   rst_n            in   1   asynchronous active-low reset
//   start            in   1   begin sweep (honoured in IDLE/DONE only)
//   vec_out          out  10  {a,b,c,d,e,f,g,h,i,j} driven into case8
//   dut_y            in   5   {y5,y4,y3,y2,y1} returned from case8
//   busy             out  1   sweep in progress (SETTLE/CHECK)
//   done             out  1   sweep finished, held until next start/reset
//   pass             out  1   done with zero mismatches
//   err_count        out  11  mismatching vectors (0..1024)
//   first_err_vec    out  10  vector of the first mismatch
//   first_err_valid  out  1   first_err_vec holds a captured vector
// -----------------------------------------------------------------------------
module case8_stim_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int START_VEC     = 0,
    parameter int END_VEC       = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  vec_out,
    input  logic [4:0]  dut_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic [9:0]  first_err_vec,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [9:0] START_V     = 10'(START_VEC);
    localparam logic [9:0] END_V       = 10'(END_VEC);
    // Counter runs 0..SETTLE_CYCLES-1, so SETTLE lasts exactly SETTLE_CYCLES.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t       state_reg, state_next;
    logic [9:0]   vec_reg, vec_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [10:0]  err_reg, err_next;
    logic [9:0]   fev_reg, fev_next;
    logic         fvalid_reg, fvalid_next;

    // ------------------------------------------------------------------
    // Golden model of case8, evaluated on the vector currently driven.
    // ------------------------------------------------------------------
    logic a, b, c, d, e, f, g, h, i, j;
    logic p, q, r;
    logic [4:0] golden_y;
    logic [4:0] diff;
    logic       mismatch;

    assign {a, b, c, d, e, f, g, h, i, j} = vec_reg;

    assign p = (a | b) & c & d;
    assign q = g | h | (e ^ f);
    assign r = i & j;

    assign golden_y[0] = p & (q | r);
    assign golden_y[1] = (q & r) | (p & ~q);
    assign golden_y[2] = p ? ~(q | r) : (q & r);
    assign golden_y[3] = (q & r) | (p & (q | r));
    assign golden_y[4] = (q & r) | p;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cmp
            assign diff[gi] = dut_y[gi] ^ golden_y[gi];
        end
    endgenerate

    assign mismatch = |diff;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            vec_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= '0;
            fev_reg    <= '0;
            fvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            vec_reg    <= vec_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
            fev_reg    <= fev_next;
            fvalid_reg <= fvalid_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        vec_next    = vec_reg;
        cnt_next    = cnt_reg;
        err_next    = err_reg;
        fev_next    = fev_reg;
        fvalid_next = fvalid_reg;

        case (state_reg)
            IDLE, DONE: begin
                // A new sweep discards the previous results entirely.
                if (start) begin
                    state_next  = SETTLE;
                    vec_next    = START_V;
                    cnt_next    = '0;
                    err_next    = '0;
                    fev_next    = '0;
                    fvalid_next = 1'b0;
                end
            end

            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = CHECK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    // Saturate rather than wrap; the range cannot exceed
                    // 1024 anyway, this only guards against misuse.
                    if (err_reg != '1) begin
                        err_next = err_reg + 11'd1;
                    end
                    if (!fvalid_reg) begin
                        fev_next    = vec_reg;
                        fvalid_next = 1'b1;
                    end
                end
`ifdef CASE8_STOP_ON_ERR_EN
                if (mismatch || (vec_reg == END_V)) begin
                    state_next = DONE;
                end else begin
                    vec_next   = vec_reg + 10'd1;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
`else
                // Terminate on END_V before incrementing so vec_out never
                // wraps when END_VEC is 1023.
                if (vec_reg == END_V) begin
                    state_next = DONE;
                end else begin
                    vec_next   = vec_reg + 10'd1;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vec_out         = vec_reg;
    assign busy            = (state_reg == SETTLE) || (state_reg == CHECK);
    assign done            = (state_reg == DONE);
    assign pass            = done && (err_reg == '0);
    assign err_count       = err_reg;
    assign first_err_vec   = fev_reg;
    assign first_err_valid = fvalid_reg;

endmodule

// File: tb/tb_case8_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_case8_stim_checker
//
// Two checker instances: dut0 with default parameters (full sweep) and dut1
// sweeping the single vector 5 with SETTLE_CYCLES=1. A behavioural case8
// model, optionally with a stuck-at fault, closes the loop on each vec_out.
// Each start that should complete pushes its expected results into a queue;
// a monitor pops and compares whenever an instance raises done.
// -----------------------------------------------------------------------------
module tb_case8_stim_checker;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic [9:0]  vec0, vec1;
    logic [4:0]  y0, y1;
    logic        busy0, busy1, done0, done1, pass0, pass1, fval0, fval1;
    logic [10:0] errc0, errc1;
    logic [9:0]  fev0, fev1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode     = 0;   // 0: correct case8, 1: y1 stuck-at-0, 2: y5 stuck-at-1

    typedef struct {
        int which;
        int cycles;
        int errc;
        int fev;
        int fval;
        int pass;
        int vec;
        int start_cyc;
    } exp_t;

    exp_t sb[$];

    // Behavioural case8 written from its truth description.
    function automatic logic [4:0] case8_model(input logic [9:0] v, input int m);
        logic pp, qq, rr;
        logic [4:0] y;
        pp = (v[9] | v[8]) & v[7] & v[6];
        qq = v[3] | v[2] | (v[5] ^ v[4]);
        rr = v[1] & v[0];
        y[0] = pp && (qq || rr);
        y[1] = (qq && rr) || (pp && !qq);
        y[2] = pp ? !(qq || rr) : (qq && rr);
        y[3] = (qq && rr) || (pp && (qq || rr));
        y[4] = (qq && rr) || pp;
        if (m == 1) y[0] = 1'b0;
        if (m == 2) y[4] = 1'b1;
        return y;
    endfunction

    assign y0 = case8_model(vec0, mode);
    assign y1 = case8_model(vec1, mode);

    case8_stim_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0),
        .first_err_vec(fev0), .first_err_valid(fval0)
    );

    case8_stim_checker #(.SETTLE_CYCLES(1), .START_VEC(5), .END_VEC(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(errc1),
        .first_err_vec(fev1), .first_err_valid(fval1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare on each rising done
    // ------------------------------------------------------------------
    task automatic check_done(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            chk($sformatf("unexpected_done_dut%0d", k), 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("sb_instance", k, e.which);
        if (k == 0) begin
            chk("dut0_done_latency", cyc - e.start_cyc, e.cycles);
            chk("dut0_err_count", int'(errc0), e.errc);
            chk("dut0_first_err_vec", int'(fev0), e.fev);
            chk("dut0_first_err_valid", int'(fval0), e.fval);
            chk("dut0_pass", int'(pass0), e.pass);
            chk("dut0_vec_out", int'(vec0), e.vec);
            chk("dut0_busy_at_done", int'(busy0), 0);
        end else begin
            chk("dut1_done_latency", cyc - e.start_cyc, e.cycles);
            chk("dut1_err_count", int'(errc1), e.errc);
            chk("dut1_first_err_vec", int'(fev1), e.fev);
            chk("dut1_first_err_valid", int'(fval1), e.fval);
            chk("dut1_pass", int'(pass1), e.pass);
            chk("dut1_vec_out", int'(vec1), e.vec);
            chk("dut1_busy_at_done", int'(busy1), 0);
        end
    endtask

    initial begin
        logic dp0, dp1;
        dp0 = 1'b0;
        dp1 = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && !dp0) check_done(0);
            if (done1 && !dp1) check_done(1);
            dp0 = done0;
            dp1 = done1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Pulse start for one cycle; sc is the cycle index of the sampling edge.
    task automatic pulse_start(input int k, output int sc);
        @(negedge clk);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        sc = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic sweep(input int k, input int cycles, input int errc, input int fev,
                         input int fval, input int pss, input int vec);
        exp_t e;
        int   sc;
        pulse_start(k, sc);
        e.which = k; e.cycles = cycles; e.errc = errc; e.fev = fev;
        e.fval = fval; e.pass = pss; e.vec = vec; e.start_cyc = sc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int k, input int limit);
        int n = 0;
        while (((k == 0) ? done0 : done1) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk($sformatf("dut%0d_done_timeout", k), 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_vec_out", int'(vec0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err_count", int'(errc0), 0);
        chk("rst_first_err_vec", int'(fev0), 0);
        chk("rst_first_err_valid", int'(fval0), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int sc;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        chk("rst_dut1_vec_out", int'(vec1), 0);
        chk("rst_dut1_done", int'(done1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct DUT, full sweep, with a start re-pulse mid-sweep.
        mode = 0;
        sweep(0, 3072, 0, 0, 0, 1, 1023);
        repeat (1500) @(negedge clk);
        chk("mid_sweep_busy", int'(busy0), 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 4000);

        // y1 stuck-at-0.
        mode = 1;
`ifdef CASE8_STOP_ON_ERR_EN
        sweep(0, 1356, 1, 451, 1, 0, 451);
`else
        sweep(0, 3072, 174, 451, 1, 0, 1023);
`endif
        wait_done(0, 4000);

        // y5 stuck-at-1.
        mode = 2;
`ifdef CASE8_STOP_ON_ERR_EN
        sweep(0, 3, 1, 0, 1, 0, 0);
`else
        sweep(0, 3072, 650, 0, 1, 0, 1023);
`endif
        wait_done(0, 4000);

        // Reset mid-sweep at cycle 1000 after start; vector 333 is in flight.
        mode = 0;
        pulse_start(0, sc);
        repeat (1000) @(posedge clk);
        #1;
        chk("pre_reset_vec_out", int'(vec0), 333);
        chk("pre_reset_busy", int'(busy0), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_done", int'(done0), 0);

        // Clean full sweep after reset.
        sweep(0, 3072, 0, 0, 0, 1, 1023);
        wait_done(0, 4000);

        // Single-vector instance: correct, then y5 stuck-at-1 (vector 5 has y5=0).
        mode = 0;
        sweep(1, 2, 0, 0, 0, 1, 5);
        wait_done(1, 50);
        mode = 2;
        sweep(1, 2, 1, 5, 1, 0, 5);
        wait_done(1, 50);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
